// File: rtl/int_timer_dev_if.sv
// -----------------------------------------------------------------------------
// int_timer_dev_if
// Data-bus view of the interrupt timer as seen from the system bridge.
//   addr    32  byte address (core m_data_addr)
//   wdata   32  write data (core m_data_wdata)
//   byteen   4  byte write enables (core m_data_byteen); any set bit = write
//   rdata   32  combinational read data from the timer
//   irq      1  level interrupt to the core interrupt input
// master: the core/bridge side; slave: the timer.
// -----------------------------------------------------------------------------
interface int_timer_dev_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output wdata,
        output byteen,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  wdata,
        input  byteen,
        output rdata,
        output irq
    );
endinterface

// File: rtl/int_timer_dev.sv
// -----------------------------------------------------------------------------
// int_timer_dev
// Memory-mapped down-counting timer used as the core's interrupt source.
// Register map (offset from BASE_ADDR):
//   0x00 CTRL   bit0 EN, bits2:1 MODE (01 auto-reload, else one-shot), bit3 IM
//   0x04 PRESET reload value, byte-merged writes
//   0x08 COUNT  current count, read-only
//   0x20 ACK    any write clears the pending flag; reads 0
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low; clears all state while low
//   bus    int_timer_dev_if.slave (addr, wdata, byteen in; rdata, irq out)
// irq = pending & IM, driven only from registers.
// -----------------------------------------------------------------------------
module int_timer_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic            clk,
    input  logic            reset,
    int_timer_dev_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_next;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;

    logic        hit;
    logic        wr;
    logic        wr_ctrl, wr_preset, wr_ack;
    logic        load_cnt, dec_cnt, zero_cnt, set_pend, clr_en;

    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;

    assign ctrl_en   = ctrl[0];
    assign ctrl_mode = ctrl[2:1];
    assign ctrl_im   = ctrl[3];

    // Update only the bytes whose enable bit is set.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

    assign hit       = (bus.addr[31:6] == BASE_ADDR[31:6]);
    assign wr        = hit && (bus.byteen != 4'b0000);
    assign wr_ctrl   = wr && (bus.addr[5:0] == 6'h00);
    assign wr_preset = wr && (bus.addr[5:0] == 6'h04);
    assign wr_ack    = wr && (bus.addr[5:0] == 6'h20);

    // Next-state and per-state actions.
    always_comb begin
        state_next = state;
        load_cnt   = 1'b0;
        dec_cnt    = 1'b0;
        zero_cnt   = 1'b0;
        set_pend   = 1'b0;
        clr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_en) state_next = LOAD;
            end
            LOAD: begin
                load_cnt   = 1'b1;
                state_next = CNT;
            end
            CNT: begin
                if (!ctrl_en) begin
                    state_next = IDLE;
                end else if (count <= 32'd1) begin
                    // Covers PRESET=0 as well: never decrement below zero.
                    zero_cnt   = 1'b1;
                    set_pend   = 1'b1;
                    state_next = INT;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            INT: begin
                if ((ctrl_mode == 2'b01) && ctrl_en) begin
                    state_next = LOAD;
                end else begin
                    clr_en     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Only byte 0 of CTRL holds state; a CTRL write beats the one-shot EN clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= 4'b0;
        end else if (wr_ctrl && bus.byteen[0]) begin
            ctrl <= bus.wdata[3:0];
        end else if (clr_en) begin
            ctrl[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         preset <= 32'b0;
        else if (wr_preset) preset <= merge_bytes(preset, bus.wdata, bus.byteen);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        count <= 32'b0;
        else if (load_cnt) count <= preset;
        else if (zero_cnt) count <= 32'b0;
        else if (dec_cnt)  count <= count - 32'd1;
    end

    // Setting has priority over an ACK on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        pending <= 1'b0;
        else if (set_pend) pending <= 1'b1;
        else if (wr_ack)   pending <= 1'b0;
    end

    always_comb begin
        bus.rdata = 32'b0;
        if (hit) begin
            case (bus.addr[5:0])
                6'h00:   bus.rdata = {28'b0, ctrl};
                6'h04:   bus.rdata = preset;
                6'h08:   bus.rdata = count;
                default: bus.rdata = 32'b0;
            endcase
        end
    end

    assign bus.irq = pending & ctrl_im;

endmodule

// File: doc/int_timer_dev.md
# int_timer_dev

Memory-mapped programmable timer that is the interrupt source feeding the `mips` core's `interrupt` input. It sits on the system bridge beside data memory and is driven by the core's data-bus signals (`m_data_addr`, `m_data_wdata`, `m_data_byteen`). It counts down a preset value and raises a level interrupt that stays asserted until the handler stores to the acknowledge address (0x7F20). It supports one-shot and auto-reload modes.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_7F00, device base; must be 64-byte aligned; decode is addr[31:6] == BASE_ADDR[31:6]

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately while low
- addr  in  32  byte address from `m_data_addr`
- wdata  in  32  write data from `m_data_wdata`
- byteen  in  4  byte write enables from `m_data_byteen`; a write occurs when any bit is set and the address decodes
- rdata  out  32  combinational read data
- irq  out  1  level interrupt to the core `interrupt` input; irq = pending & CTRL.IM

## Operation
- Register map (offset from BASE_ADDR):
  - 0x00 CTRL: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), bit3 IM; bits31:4 read 0.
  - 0x04 PRESET: 32-bit read/write.
  - 0x08 COUNT: read-only; writes are ignored.
  - 0x20 ACK: a write with any byteen bit set clears `pending`; reads return 0.
  - Other offsets: writes are ignored and reads return 0.
- Writes merge bytewise: only bytes whose byteen bit is set update CTRL and PRESET.
- Reset values: CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE, irq=0, rdata reflects current registers.
- FSM states are IDLE, LOAD, CNT and INT:
  - IDLE: if EN=1, go to LOAD. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE and freeze COUNT.
    - Else if COUNT <= 1, COUNT <= 0, set pending, go to INT.
    - Else decrement COUNT.
  - INT:
    - MODE=01 and EN=1: go to LOAD.
    - Otherwise: clear CTRL.EN (unless a CTRL write in the same cycle sets it) and go to IDLE.
- A PRESET write during CNT affects only the next LOAD.
- A CTRL write is seen by the FSM on the following edge.
- If set-pending and an ACK write occur in the same cycle, set wins and pending stays 1.
- IM=0 masks irq but does not clear pending; setting IM later asserts irq immediately.
- COUNT decrements as a 32-bit unsigned value and never wraps below 0.
- When reset is asserted mid-count, all state returns to reset values asynchronously and irq drops in the same cycle.

## Timing
- The EN write takes effect at edge t.
- For PRESET=P with P >= 1:
  - IDLE→LOAD at t+1.
  - COUNT=P at t+2.
  - COUNT=P-k at t+2+k.
  - pending=1 and COUNT=0 at t+2+P.
- For PRESET=0, pending=1 at t+3.
- irq is registered-output timing: it rises in the cycle after the edge that sets pending, with no combinational path from the bus.
- Auto-reload period is P+2 cycles between successive pending set edges.
- An ACK write at edge a clears irq after edge a.
- rdata is purely combinational from addr, with zero latency. A read of COUNT in the same cycle as a decrement returns the pre-edge value.

## Test plan
- Reset and readback: hold reset low for 3 cycles, then read 0x00/0x04/0x08. Required: all read 0 and irq=0; an ACK read returns 0.
- One-shot: write PRESET=5, then CTRL=0x9 (EN, IM, mode 0). Required: COUNT reads 5,4,3,2,1,0 on consecutive cycles; irq rises 7 edges after the CTRL write; CTRL reads 0x8 afterwards. Writing ACK drops irq next cycle and irq stays low.
- Auto-reload: PRESET=3, CTRL=0xB. Required: pending set edges are 5 cycles apart; with no ACK, irq stays high; after ACK, irq drops and re-rises one period later.
- Byte merge and mask: PRESET=0x11223344, then a write of 0xAABBCCDD with byteen=0100. Required: PRESET=0x11BB3344. With CTRL=0x1 (IM=0), after expiry irq=0 and pending is held; a write of CTRL=0x8 raises irq next cycle.
- Collisions: an ACK write on the same edge that pending sets leaves irq=1. Clearing EN mid-count freezes COUNT; re-setting EN reloads PRESET rather than resuming.
- Async reset mid-count: pulse reset low between edges with COUNT=7. Required: COUNT=0, irq=0 and state IDLE immediately, and no irq after reset is released.
